// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding and load-use hazard detection for a 5-stage pipeline.
// Tracks EX/MEM/WB instruction records and counts load-use stall cycles.
module fwd_hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    output logic [1:0]       forward_A,
    output logic [1:0]       forward_B,
    output logic             load_use_stall,
    output logic [CNT_W-1:0] load_use_cnt
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } ex_rec_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } mem_rec_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
    } wb_rec_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    ex_rec_t  ex_q;
    mem_rec_t mem_q;
    wb_rec_t  wb_q;

    logic mem_fwd_a, mem_fwd_b, wb_fwd_a, wb_fwd_b;
    logic mem_producer, wb_producer;

    // x0 is hard-wired zero, so it is never a forwarding source.
    assign mem_producer = mem_q.valid && mem_q.reg_write && (mem_q.rd != 5'd0);
    assign wb_producer  = wb_q.valid && wb_q.reg_write && (wb_q.rd != 5'd0);

    assign mem_fwd_a = mem_producer && (mem_q.rd == ex_q.rs1);
    assign mem_fwd_b = mem_producer && (mem_q.rd == ex_q.rs2);
    assign wb_fwd_a  = wb_producer && (wb_q.rd == ex_q.rs1);
    assign wb_fwd_b  = wb_producer && (wb_q.rd == ex_q.rs2);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        forward_A = FWD_RF;
        forward_B = FWD_RF;
        if (ex_q.valid) begin
            if (mem_fwd_a)     forward_A = FWD_MEM;
            else if (wb_fwd_a) forward_A = FWD_WB;
            if (mem_fwd_b)     forward_B = FWD_MEM;
            else if (wb_fwd_b) forward_B = FWD_WB;
        end
    end

    // A flushed ID instruction is dead, so it cannot cause a load-use stall.
    assign load_use_stall = !flush && id_valid && ex_q.valid && ex_q.mem_read &&
                            (ex_q.rd != 5'd0) &&
                            ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));

    // NOTE: sequential state uses non-blocking assignments so every record samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q         <= '0;
            mem_q        <= '0;
            wb_q         <= '0;
            load_use_cnt <= '0;
        end else if (!stall) begin
            if (flush || load_use_stall) begin
                ex_q <= '0;
            end else begin
                ex_q.valid     <= id_valid;
                ex_q.rs1       <= id_rs1;
                ex_q.rs2       <= id_rs2;
                ex_q.rd        <= id_rd;
                ex_q.reg_write <= id_reg_write;
                ex_q.mem_read  <= id_mem_read;
            end
            mem_q.valid     <= ex_q.valid;
            mem_q.rd        <= ex_q.rd;
            mem_q.reg_write <= ex_q.reg_write;
            mem_q.mem_read  <= ex_q.mem_read;
            wb_q.valid      <= mem_q.valid;
            wb_q.rd         <= mem_q.rd;
            wb_q.reg_write  <= mem_q.reg_write;
            if (load_use_stall && (load_use_cnt != {CNT_W{1'b1}})) begin
                load_use_cnt <= load_use_cnt + 1'b1;
            end
        end
    end

endmodule
